// File: rtl/mips_core_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcode/funct encodings,
// the ALU operation enum and the five-state control FSM enum.
package mips_core_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_e;

endpackage

// File: rtl/mips_multicycle_core_if.sv
// Instruction handshake and data-memory bus of the multi-cycle core.
//   instr_valid/instr_ready/instruction : instruction offer (valid/ready)
//   dmem_req/we/addr/wdata              : memory request, held until ack
//   dmem_rdata/dmem_ack                 : memory completion, rdata valid with ack
// master = core side, slave = instruction source / memory side.
interface mips_multicycle_core_if #(
  parameter int DATA_W  = 32,
  parameter int DMEM_AW = 8
);
  logic               instr_valid;
  logic               instr_ready;
  logic [31:0]        instruction;
  logic               dmem_req;
  logic               dmem_we;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic [DATA_W-1:0]  dmem_rdata;
  logic               dmem_ack;

  modport master (
    input  instr_valid, instruction, dmem_rdata, dmem_ack,
    output instr_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata
  );

  modport slave (
    output instr_valid, instruction, dmem_rdata, dmem_ack,
    input  instr_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata
  );
endinterface

// File: rtl/mips_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// asynchronous active-low clear. r0 always reads zero and ignores writes.
//   clk, rst_n        : clock, async clear
//   raddr_a/b, rdata_a/b : combinational read ports
//   we, waddr, wdata  : write port, committed on rising clk
module mips_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     raddr_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);
  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];
endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core (add/sub/and/or/slt, addi, lw, sw, beq).
// One instruction per valid/ready handshake, sequenced through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB). Data memory is reached through a
// req/ack handshake that tolerates any number of wait cycles.
//   clk, reset  : clock, async active-low reset
//   bus         : instruction handshake + data-memory bus (master side)
//   pc          : program counter
//   alu_result, zero : registered ALU output / zero flag
//   wb_valid, wb_reg, wb_data : one-cycle pulse describing a register write
//   illegal     : one-cycle pulse for unsupported op/funct or misaligned lw/sw
module mips_multicycle_core
  import mips_core_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 32,
  parameter int DMEM_AW = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  mips_multicycle_core_if.master  bus,
  output logic [DATA_W-1:0]       pc,
  output logic [DATA_W-1:0]       alu_result,
  output logic                    zero,
  output logic                    wb_valid,
  output logic [4:0]              wb_reg,
  output logic [DATA_W-1:0]       wb_data,
  output logic                    illegal
);
  localparam int AW = $clog2(NREGS);

  state_e state, state_n;

  logic [31:0]       ir;
  logic [DATA_W-1:0] a, b, imm, mdr;
  logic [DATA_W-1:0] rd_a, rd_b;

  // decode straight off IR; IR is stable from DECODE until the next accept
  logic [5:0] op, funct;
  logic [4:0] rd, rt, wb_dst;
  assign op    = ir[31:26];
  assign funct = ir[5:0];
  assign rt    = ir[20:16];
  assign rd    = ir[15:11];

  logic is_r, is_lw, is_sw, is_beq, is_addi, is_mem, r_ok, dec_ok;
  assign is_r    = (op == OP_RTYPE);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign is_addi = (op == OP_ADDI);
  assign is_mem  = is_lw | is_sw;
  assign r_ok    = (funct == FN_ADD) | (funct == FN_SUB) | (funct == FN_AND) |
                   (funct == FN_OR)  | (funct == FN_SLT);
  assign dec_ok  = (is_r & r_ok) | is_mem | is_beq | is_addi;

  logic [DATA_W-1:0] imm_ext;
  assign imm_ext = DATA_W'($signed(ir[15:0]));

  // ALU
  alu_op_e           alu_op;
  logic [DATA_W-1:0] alu_b, alu_y;

  always_comb begin
    alu_op = ALU_ADD;
    if (is_beq) alu_op = ALU_SUB;
    else if (is_r) begin
      case (funct)
        FN_SUB:  alu_op = ALU_SUB;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_SLT:  alu_op = ALU_SLT;
        default: alu_op = ALU_ADD;
      endcase
    end
  end

  assign alu_b = (is_addi | is_mem) ? imm : b;

  always_comb begin
    alu_y = '0;
    case (alu_op)
      ALU_ADD: alu_y = a + alu_b;
      ALU_SUB: alu_y = a - alu_b;
      ALU_AND: alu_y = a & alu_b;
      ALU_OR:  alu_y = a | alu_b;
      ALU_SLT: alu_y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(alu_b))};
      default: alu_y = '0;
    endcase
  end

  logic              misaligned;
  logic [DATA_W-1:0] pc_inc, br_target, wb_val;
  assign misaligned = (alu_y[1:0] != 2'b00);
  assign pc_inc     = pc + DATA_W'(4);
  assign br_target  = pc_inc + (imm << 2);
  assign wb_dst     = is_r ? rd : rt;
  assign wb_val     = is_lw ? mdr : alu_result;

  mips_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
    .clk     (clk),
    .rst_n   (reset),
    .raddr_a (ir[21 +: AW]),
    .raddr_b (ir[16 +: AW]),
    .rdata_a (rd_a),
    .rdata_b (rd_b),
    .we      (state == WB),
    .waddr   (wb_dst[AW-1:0]),
    .wdata   (wb_val)
  );

  // FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      FETCH:  if (bus.instr_valid) state_n = DECODE;
      DECODE: state_n = dec_ok ? EXEC : FETCH;
      EXEC: begin
        if (is_beq)      state_n = FETCH;
        else if (is_mem) state_n = misaligned ? FETCH : MEM;
        else             state_n = WB;
      end
      MEM:    if (bus.dmem_ack) state_n = is_lw ? WB : FETCH;
      WB:     state_n = FETCH;
      default: state_n = FETCH;
    endcase
  end

  // datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir         <= '0;
      a          <= '0;
      b          <= '0;
      imm        <= '0;
      mdr        <= '0;
      pc         <= '0;
      alu_result <= '0;
      zero       <= 1'b0;
      wb_valid   <= 1'b0;
      wb_reg     <= '0;
      wb_data    <= '0;
      illegal    <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      illegal  <= 1'b0;
      case (state)
        FETCH: if (bus.instr_valid) ir <= bus.instruction;
        DECODE: begin
          a   <= rd_a;
          b   <= rd_b;
          imm <= imm_ext;
          if (!dec_ok) begin
            illegal <= 1'b1;
            pc      <= pc_inc;
          end
        end
        EXEC: begin
          alu_result <= alu_y;
          zero       <= (alu_y == '0);
          if (is_beq) pc <= (alu_y == '0) ? br_target : pc_inc;
          else begin
            pc <= pc_inc;
            if (is_mem && misaligned) illegal <= 1'b1;
          end
        end
        MEM: if (bus.dmem_ack) mdr <= bus.dmem_rdata;
        WB: begin
          // r0 write is dropped in the regfile, but the pulse is still shown
          wb_valid <= 1'b1;
          wb_reg   <= wb_dst;
          wb_data  <= wb_val;
        end
        default: ;
      endcase
    end
  end

  // req decodes straight from state so an async reset drops it immediately
  assign bus.instr_ready = (state == FETCH);
  assign bus.dmem_req    = (state == MEM);
  assign bus.dmem_we     = (state == MEM) & is_sw;
  assign bus.dmem_addr   = alu_result[DMEM_AW+1:2];
  assign bus.dmem_wdata  = b;
endmodule
